// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the memory access sequencer: FSM state encoding
// and the default size of the attached data memory.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int DEFAULT_MEM_SIZE_BYTES = 8192;
  localparam int DEFAULT_TAG_WIDTH      = 6;

endpackage

// File: rtl/load_extend.sv
// load_extend
// Combinational load-result formatter.
// Ports:
//   raw_value   in  32  value returned by the memory
//   byte_access in  1   1 = byte load, 0 = word load
//   sign_extend in  1   sign-extend byte loads (ignored for words)
//   ext_value   out 32  formatted load result
module load_extend (
  input  logic [31:0] raw_value,
  input  logic        byte_access,
  input  logic        sign_extend,
  output logic [31:0] ext_value
);

  always_comb begin
    ext_value = raw_value;
    if (byte_access) begin
      if (sign_extend) ext_value = {{24{raw_value[7]}}, raw_value[7:0]};
      else             ext_value = {24'b0, raw_value[7:0]};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Accepts one load/store at a time, drives data_memory until its completion
// pulse, then returns a tagged, formatted response. Out-of-range requests
// answer with an error and never touch the memory. Flushed loads run to
// completion in the memory but their response is dropped.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_*                           request channel (valid/ready)
//   flush                           kill in-flight / pending load result
//   resp_*                          one-cycle response
//   mem_*                           data_memory pins
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; bounds-check and latch on handshake
// WRITE | store in progress, write enable held until mem_write_valid
// READ  | load in progress, read enable held until mem_read_valid
// RESP  | present response for one cycle (unless a killed load)
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TAG_WIDTH      = DEFAULT_TAG_WIDTH,
  parameter int MEM_SIZE_BYTES = DEFAULT_MEM_SIZE_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic                 req_byte,
  input  logic                 req_signed,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_data,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic                 flush,
  output logic                 resp_valid,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic [31:0]          resp_data,
  output logic                 resp_is_store,
  output logic                 resp_error,
  output logic                 mem_write_enable,
  output logic                 mem_read_enable,
  output logic                 mem_store_byte,
  output logic                 mem_load_byte,
  output logic [31:0]          mem_write_address,
  output logic [31:0]          mem_read_address,
  output logic [31:0]          mem_write_value,
  input  logic [31:0]          mem_read_value,
  input  logic                 mem_write_valid,
  input  logic                 mem_read_valid
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_WRITE = ST_WRITE;
  localparam logic [1:0] S_READ  = ST_READ;
  localparam logic [1:0] S_RESP  = ST_RESP;

  logic [1:0]           state;
  logic                 kill_q;
  logic                 store_q;
  logic                 byte_q;
  logic                 signed_q;
  logic                 err_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic [TAG_WIDTH-1:0] tag_q;

  logic [32:0] last_byte;
  logic        in_range;
  logic [31:0] ext_value;
  logic        suppress;

  // 33-bit sum so an address near 2^32 cannot wrap back into range
  assign last_byte = {1'b0, req_addr} + (req_byte ? 33'd0 : 33'd3);
  assign in_range  = last_byte < 33'(MEM_SIZE_BYTES);

  load_extend u_load_extend (
    .raw_value   (mem_read_value),
    .byte_access (byte_q),
    .sign_extend (signed_q),
    .ext_value   (ext_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      kill_q   <= 1'b0;
      store_q  <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      tag_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          kill_q <= 1'b0;
          if (req_valid && req_ready) begin
            store_q  <= req_is_store;
            byte_q   <= req_byte;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_data;
            tag_q    <= req_tag;
            rdata_q  <= 32'd0;
            err_q    <= ~in_range;
            if (!in_range)        state <= S_RESP;
            else if (req_is_store) state <= S_WRITE;
            else                  state <= S_READ;
          end
        end
        S_WRITE: begin
          if (mem_write_valid) state <= S_RESP;
        end
        S_READ: begin
          // the load keeps running so the memory's counter finishes cleanly
          if (flush) kill_q <= 1'b1;
          if (mem_read_valid) begin
            rdata_q <= ext_value;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          kill_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE) && !flush;

  // gating on the valid pulse keeps the memory from starting a second count
  assign mem_write_enable  = (state == S_WRITE) && !mem_write_valid;
  assign mem_read_enable   = (state == S_READ) && !mem_read_valid;
  assign mem_store_byte    = byte_q;
  assign mem_load_byte     = byte_q;
  assign mem_write_address = addr_q;
  assign mem_read_address  = addr_q;
  assign mem_write_value   = wdata_q;

  // only successful loads can be killed; stores and errors always respond
  assign suppress      = !store_q && !err_q && (kill_q || flush);
  assign resp_valid    = (state == S_RESP) && !suppress;
  assign resp_tag      = tag_q;
  assign resp_data     = rdata_q;
  assign resp_is_store = store_q;
  assign resp_error    = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int L = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;
  logic [5:0]  req_tag = 6'd0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [5:0]  resp_tag;
  logic [31:0] resp_data;
  logic        resp_is_store;
  logic        resp_error;
  logic        mem_write_enable, mem_read_enable, mem_store_byte, mem_load_byte;
  logic [31:0] mem_write_address, mem_read_address, mem_write_value;
  logic [31:0] mem_read_value;
  logic        mem_write_valid, mem_read_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TAG_WIDTH(6), .MEM_SIZE_BYTES(8192)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_data(req_data), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
    .resp_is_store(resp_is_store), .resp_error(resp_error),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_store_byte(mem_store_byte), .mem_load_byte(mem_load_byte),
    .mem_write_address(mem_write_address), .mem_read_address(mem_read_address),
    .mem_write_value(mem_write_value), .mem_read_value(mem_read_value),
    .mem_write_valid(mem_write_valid), .mem_read_valid(mem_read_valid)
  );

  // data_memory model: counts enable cycles, pulses valid after L of them.
  // An enable left high in the valid cycle would start a new count and
  // shorten the next access.
  logic [7:0] mem [0:8191];
  int wcnt, rcnt;
  int wa, ra;

  initial for (int i = 0; i < 8192; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      wcnt <= 0; rcnt <= 0;
      mem_write_valid <= 1'b0; mem_read_valid <= 1'b0;
      mem_read_value <= 32'd0;
    end else begin
      mem_write_valid <= 1'b0;
      mem_read_valid  <= 1'b0;
      if (mem_write_enable) begin
        if (wcnt == L - 1) begin
          wcnt <= 0;
          mem_write_valid <= 1'b1;
          wa = int'(mem_write_address[12:0]);
          mem[wa] <= mem_write_value[7:0];
          if (!mem_store_byte) begin
            mem[wa+1] <= mem_write_value[15:8];
            mem[wa+2] <= mem_write_value[23:16];
            mem[wa+3] <= mem_write_value[31:24];
          end
        end else wcnt <= wcnt + 1;
      end
      if (mem_read_enable) begin
        if (rcnt == L - 1) begin
          rcnt <= 0;
          mem_read_valid <= 1'b1;
          ra = int'(mem_read_address[12:0]);
          if (mem_load_byte) mem_read_value <= {24'hA5A5A5, mem[ra]};
          else mem_read_value <= {mem[ra+3], mem[ra+2], mem[ra+1], mem[ra]};
        end else rcnt <= rcnt + 1;
      end
    end
  end

  // results of the last run_req
  int          resp_cyc, ready_cyc, we_n, re_n, resp_n;
  logic        overlap;
  logic [31:0] r_data;
  logic [5:0]  r_tag;
  logic        r_store, r_err;

  task automatic run_req(input logic st, input logic byt, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [5:0] tag, input int flush_cyc);
    resp_cyc = -1; ready_cyc = -1; we_n = 0; re_n = 0; resp_n = 0; overlap = 1'b0;
    r_data = 32'hx; r_tag = 6'hx; r_store = 1'bx; r_err = 1'bx;
    @(negedge clk);
    req_is_store = st; req_byte = byt; req_signed = sgn;
    req_addr = addr; req_data = data; req_tag = tag; req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_before_req got %b exp 1", req_ready);
    end
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_write_enable) we_n++;
      if (mem_read_enable) re_n++;
      if (mem_write_enable && mem_read_enable) overlap = 1'b1;
      if (resp_valid) begin
        resp_n++; resp_cyc = k;
        r_data = resp_data; r_tag = resp_tag; r_store = resp_is_store; r_err = resp_error;
      end
      if (k == 1) req_valid = 1'b0;
      flush = (k == flush_cyc);
      if (req_ready && k > 1) begin
        ready_cyc = k;
        break;
      end
    end
    flush = 1'b0;
    checks++;
    if (ready_cyc < 0) begin
      errors++; $display("FAIL timeout_ready got -1 exp ready within 40 cycles");
    end
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_write_enable !== 1'b0 ||
        mem_read_enable !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got ready=%b rv=%b we=%b re=%b exp 1 0 0 0",
                         req_ready, resp_valid, mem_write_enable, mem_read_enable);
    end
    checks++;
    if ({mem_write_address, mem_read_address, mem_write_value, resp_data} !== 128'd0 ||
        {resp_tag, resp_is_store, resp_error, mem_store_byte, mem_load_byte} !== 10'd0) begin
      errors++; $display("FAIL reset_data got wa=%h ra=%h wv=%h rd=%h tag=%h exp all 0",
                         mem_write_address, mem_read_address, mem_write_value, resp_data, resp_tag);
    end
  endtask

  task automatic test_word();
    run_req(1'b1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 6'd5, 0);
    checks++;
    if (resp_cyc !== 12 || ready_cyc !== 13) begin
      errors++; $display("FAIL word_st_timing got resp=%0d ready=%0d exp 12 13", resp_cyc, ready_cyc);
    end
    checks++;
    if (we_n !== L || re_n !== 0 || r_store !== 1'b1 || r_err !== 1'b0 || r_tag !== 6'd5 || r_data !== 32'd0) begin
      errors++; $display("FAIL word_st_resp got we=%0d re=%0d st=%b err=%b tag=%0d data=%h exp 10 0 1 0 5 0",
                         we_n, re_n, r_store, r_err, r_tag, r_data);
    end
    run_req(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 6'd9, 0);
    checks++;
    if (resp_cyc !== 12 || re_n !== L || we_n !== 0) begin
      errors++; $display("FAIL word_ld_timing got resp=%0d re=%0d we=%0d exp 12 10 0", resp_cyc, re_n, we_n);
    end
    checks++;
    if (r_data !== 32'hDEADBEEF || r_tag !== 6'd9 || r_err !== 1'b0 || r_store !== 1'b0) begin
      errors++; $display("FAIL word_ld_resp got data=%h tag=%0d err=%b st=%b exp deadbeef 9 0 0",
                         r_data, r_tag, r_err, r_store);
    end
  endtask

  task automatic test_byte();
    run_req(1'b1, 1'b1, 1'b0, 32'h200, 32'h12345680, 6'd1, 0);
    run_req(1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 6'd2, 0);
    checks++;
    if (r_data !== 32'hFFFFFF80 || resp_cyc !== 12) begin
      errors++; $display("FAIL byte_signed got data=%h cyc=%0d exp ffffff80 12", r_data, resp_cyc);
    end
    run_req(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 6'd3, 0);
    checks++;
    if (r_data !== 32'h00000080) begin
      errors++; $display("FAIL byte_unsigned got %h exp 00000080", r_data);
    end
    run_req(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 6'd4, 0);
    checks++;
    if (r_data !== 32'h00000080) begin
      errors++; $display("FAIL byte_only_one got %h exp 00000080", r_data);
    end
  endtask

  task automatic test_bounds();
    run_req(1'b0, 1'b0, 1'b0, 32'd8190, 32'h0, 6'd7, 0);
    checks++;
    if (resp_cyc !== 1 || ready_cyc !== 2 || r_err !== 1'b1 || r_data !== 32'd0 || r_tag !== 6'd7) begin
      errors++; $display("FAIL oob_word got cyc=%0d rdy=%0d err=%b data=%h tag=%0d exp 1 2 1 0 7",
                         resp_cyc, ready_cyc, r_err, r_data, r_tag);
    end
    checks++;
    if (we_n !== 0 || re_n !== 0) begin
      errors++; $display("FAIL oob_no_enable got we=%0d re=%0d exp 0 0", we_n, re_n);
    end
    run_req(1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0, 6'd8, 0);
    checks++;
    if (r_err !== 1'b1 || r_store !== 1'b1 || we_n !== 0 || resp_cyc !== 1) begin
      errors++; $display("FAIL oob_wrap got err=%b st=%b we=%0d cyc=%0d exp 1 1 0 1", r_err, r_store, we_n, resp_cyc);
    end
    run_req(1'b1, 1'b1, 1'b0, 32'd8191, 32'h0000007F, 6'd10, 0);
    run_req(1'b0, 1'b1, 1'b0, 32'd8191, 32'h0, 6'd11, 0);
    checks++;
    if (r_err !== 1'b0 || r_data !== 32'h7F || resp_cyc !== 12) begin
      errors++; $display("FAIL edge_byte got err=%b data=%h cyc=%0d exp 0 7f 12", r_err, r_data, resp_cyc);
    end
  endtask

  task automatic test_flush();
    run_req(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 6'd12, 4);
    checks++;
    if (resp_n !== 0 || re_n !== L || ready_cyc !== 13) begin
      errors++; $display("FAIL flush_load got resp=%0d re=%0d rdy=%0d exp 0 10 13", resp_n, re_n, ready_cyc);
    end
    run_req(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 6'd13, 0);
    checks++;
    if (resp_cyc !== 12 || r_data !== 32'hDEADBEEF || r_tag !== 6'd13) begin
      errors++; $display("FAIL after_flush got cyc=%0d data=%h tag=%0d exp 12 deadbeef 13", resp_cyc, r_data, r_tag);
    end
    run_req(1'b1, 1'b0, 1'b0, 32'h400, 32'h0BADF00D, 6'd14, 4);
    checks++;
    if (resp_n !== 1 || r_store !== 1'b1 || resp_cyc !== 12) begin
      errors++; $display("FAIL flush_store got resp=%0d st=%b cyc=%0d exp 1 1 12", resp_n, r_store, resp_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int acc2, r1, r2;
    logic ov;
    logic [31:0] d2;
    acc2 = -1; r1 = -1; r2 = -1; ov = 1'b0; d2 = 32'hx;
    @(negedge clk);
    req_is_store = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 32'h300; req_data = 32'h11223344; req_tag = 6'd20; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_write_enable && mem_read_enable) ov = 1'b1;
      if (resp_valid && r1 < 0) r1 = k;
      else if (resp_valid) begin r2 = k; d2 = resp_data; end
      if (req_ready && req_valid && acc2 < 0) acc2 = k;
      if (k == 1) begin req_is_store = 1'b0; req_tag = 6'd21; end
      if (acc2 >= 0 && k == acc2 + 1) req_valid = 1'b0;
      if (r2 >= 0) break;
    end
    req_valid = 1'b0;
    checks++;
    if (acc2 !== L + 3 || r1 !== 12) begin
      errors++; $display("FAIL b2b_accept got acc2=%0d r1=%0d exp 13 12", acc2, r1);
    end
    checks++;
    if (r2 !== 25 || d2 !== 32'h11223344 || ov !== 1'b0) begin
      errors++; $display("FAIL b2b_second got r2=%0d data=%h ov=%b exp 25 11223344 0", r2, d2, ov);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_is_store = 1'b1; req_byte = 1'b0; req_addr = 32'h100;
    req_data = 32'hCAFEF00D; req_tag = 6'd30; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k == 5) reset = 1'b1;
    end
    checks++;
    if (req_ready !== 1'b1 || mem_write_enable !== 1'b0 || resp_valid !== 1'b0 ||
        mem_write_address !== 32'd0 || mem_write_value !== 32'd0 || resp_tag !== 6'd0 ||
        resp_is_store !== 1'b0) begin
      errors++; $display("FAIL midreset got ready=%b we=%b rv=%b wa=%h wv=%h tag=%0d st=%b exp 1 0 0 0 0 0 0",
                         req_ready, mem_write_enable, resp_valid, mem_write_address,
                         mem_write_value, resp_tag, resp_is_store);
    end
    reset = 1'b0;
    run_req(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 6'd31, 0);
    checks++;
    if (resp_cyc !== 12 || r_data !== 32'hDEADBEEF || re_n !== L) begin
      errors++; $display("FAIL after_reset got cyc=%0d data=%h re=%0d exp 12 deadbeef 10", resp_cyc, r_data, re_n);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_bounds();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
